// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and data
// ports; data has priority, with a bounded-wait guard against fetch starvation.
module mem_port_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int READ_LATENCY   = 1,
    parameter int FETCH_MAX_WAIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InstrReq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrRdData,
    output logic                 InstrWaitreq,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataWrData,
    output logic [WORD_SIZE-1:0] DataRdData,
    output logic                 DataWaitreq,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWrData,
    output logic                 MemRdEn,
    output logic                 MemWrEn,
    input  logic [WORD_SIZE-1:0] MemRdData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [3:0] LAT_INIT  = 4'(READ_LATENCY);
    localparam logic [3:0] STARV_MAX = 4'(FETCH_MAX_WAIT);

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic                 is_wr_q, is_wr_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [3:0]           lat_q, lat_d;
    logic [3:0]           starv_q, starv_d;
    logic [WORD_SIZE-1:0] irdata_q, irdata_d;
    logic [WORD_SIZE-1:0] drdata_q, drdata_d;

    logic data_req;
    logic fetch_forced;
    logic data_wins;
    logic data_is_wr;
    logic rd_en;
    logic wr_en;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_d        = lat_q;
        starv_d      = starv_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        data_req     = ReadData | WriteData;
        fetch_forced = InstrReq && (starv_q == STARV_MAX);
        data_wins    = data_req && !fetch_forced;
        // A simultaneous read+write request degrades to a plain read.
        data_is_wr   = WriteData & ~ReadData;

        unique case (state_q)
            IDLE: begin
                if (data_req || InstrReq) begin
                    state_d = ISSUE;
                    if (data_wins) begin
                        owner_d = OWN_DATA;
                        addr_d  = DataAddr;
                        is_wr_d = data_is_wr;
                        if (data_is_wr) begin
                            wdata_d = DataWrData;
                        end
                        if (!InstrReq) begin
                            starv_d = 4'd0;
                        end else if (starv_q < STARV_MAX) begin
                            starv_d = starv_q + 4'd1;
                        end
                    end else begin
                        owner_d = OWN_FETCH;
                        addr_d  = InstrAddr;
                        is_wr_d = 1'b0;
                        starv_d = 4'd0;
                    end
                end
            end
            ISSUE: begin
                if (is_wr_q) begin
                    wr_en   = 1'b1;
                    state_d = DONE;
                end else begin
                    rd_en   = 1'b1;
                    lat_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    if (owner_q == OWN_DATA) begin
                        drdata_d = MemRdData;
                    end else begin
                        irdata_d = MemRdData;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_FETCH;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= 4'd0;
            starv_q  <= 4'd0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starv_q  <= starv_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    // Strobes are gated by Reset so an access issuing during reset never lands.
    assign MemRdEn   = rd_en & ~Reset;
    assign MemWrEn   = wr_en & ~Reset;
    assign MemAddr   = addr_q;
    assign MemWrData = wdata_q;

    assign InstrRdData = irdata_q;
    assign DataRdData  = drdata_q;

    assign InstrWaitreq = InstrReq &
        (Reset | ~(state_q == DONE && owner_q == OWN_FETCH));
    assign DataWaitreq  = (ReadData | WriteData) &
        (Reset | ~(state_q == DONE && owner_q == OWN_DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases plus randomized
// two-port traffic against a word-array reference of the memory.
module tb_mem_port_arbiter;

    localparam int W   = 16;
    localparam int RL  = 3;
    localparam int FMW = 2;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         InstrReq;
    logic [W-1:0] InstrAddr;
    logic [W-1:0] InstrRdData;
    logic         InstrWaitreq;
    logic         ReadData;
    logic         WriteData;
    logic [W-1:0] DataAddr;
    logic [W-1:0] DataWrData;
    logic [W-1:0] DataRdData;
    logic         DataWaitreq;
    logic [W-1:0] MemAddr;
    logic [W-1:0] MemWrData;
    logic         MemRdEn;
    logic         MemWrEn;
    logic [W-1:0] MemRdData;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(
        .WORD_SIZE     (W),
        .READ_LATENCY  (RL),
        .FETCH_MAX_WAIT(FMW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InstrReq    (InstrReq),
        .InstrAddr   (InstrAddr),
        .InstrRdData (InstrRdData),
        .InstrWaitreq(InstrWaitreq),
        .ReadData    (ReadData),
        .WriteData   (WriteData),
        .DataAddr    (DataAddr),
        .DataWrData  (DataWrData),
        .DataRdData  (DataRdData),
        .DataWaitreq (DataWaitreq),
        .MemAddr     (MemAddr),
        .MemWrData   (MemWrData),
        .MemRdEn     (MemRdEn),
        .MemWrEn     (MemWrEn),
        .MemRdData   (MemRdData)
    );

    function automatic logic [15:0] init_word(input int a);
        if (a == 16) return 16'hBEEF;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // Synchronous RAM with a READ_LATENCY-deep output pipe.
    logic [15:0] ram [0:1023];
    bit   [15:0] pipe [0:RL-1];
    bit          ram_init_done = 1'b0;

    always @(posedge Clock) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else if (MemWrEn) begin
            ram[MemAddr[9:0]] <= MemWrData;
        end
        pipe[0] <= ram[MemAddr[9:0]];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign MemRdData = pipe[RL-1];

    typedef struct packed {
        logic        wr;
        logic [15:0] rdata;
    } exp_t;

    logic [15:0] ref_mem [0:1023];
    exp_t        dq[$];
    logic [15:0] fq[$];
    int          checks = 0;
    int          errors = 0;
    int          dcnt   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a port completes.
    always @(negedge Clock) begin
        if (!Reset) begin
            if ((ReadData || WriteData) && !DataWaitreq) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected: completion with empty queue");
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    if (!e.wr) check("data_rd", 32'(DataRdData), 32'(e.rdata));
                end
                if (InstrReq) dcnt++;
            end
            if (InstrReq && !InstrWaitreq) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_unexpected: completion with empty queue");
                end else begin
                    logic [15:0] f;
                    f = fq.pop_front();
                    check("fetch_rd", 32'(InstrRdData), 32'(f));
                end
                checks++;
                if (dcnt > FMW + 1) begin
                    errors++;
                    $display("FAIL fetch_starve: %0d data completions, limit %0d",
                             dcnt, FMW + 1);
                end
                dcnt = 0;
            end
            if (!InstrReq) dcnt = 0;
        end
    end

    task automatic push_data(input logic wr, input logic [15:0] a,
                             input logic [15:0] wd);
        if (wr) begin
            dq.push_back('{wr: 1'b1, rdata: 16'h0});
            ref_mem[a[9:0]] = wd;
        end else begin
            dq.push_back('{wr: 1'b0, rdata: ref_mem[a[9:0]]});
        end
    endtask

    task automatic dtxn(input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input bit scramble,
                        input string tag);
        int issue_c = -1;
        int done_c  = -1;
        int rd_cnt  = 0;
        int wr_cnt  = 0;
        ReadData   = ~wr;
        WriteData  = wr;
        DataAddr   = a;
        DataWrData = wd;
        push_data(wr, a, wd);
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (MemRdEn || MemWrEn) begin
                issue_c = k;
                if (MemRdEn) rd_cnt++;
                if (MemWrEn) begin
                    wr_cnt++;
                    check({tag, "_mwdata"}, 32'(MemWrData), 32'(wd));
                end
                check({tag, "_maddr"}, 32'(MemAddr), 32'(a));
            end
            if (!DataWaitreq) begin
                done_c = k;
                break;
            end
            @(posedge Clock);
            #1;
            if (scramble) begin
                DataAddr   = 16'($urandom);
                DataWrData = 16'($urandom);
            end
        end
        check({tag, "_issue_cyc"}, 32'(issue_c), 32'd1);
        check({tag, "_rd_strobes"}, 32'(rd_cnt), wr ? 32'd0 : 32'd1);
        check({tag, "_wr_strobes"}, 32'(wr_cnt), wr ? 32'd1 : 32'd0);
        check({tag, "_done_cyc"}, 32'(done_c), wr ? 32'd2 : 32'(2 + RL));
        @(posedge Clock);
        #1;
        ReadData  = 1'b0;
        WriteData = 1'b0;
    endtask

    task automatic drv_data(input int n, input int maxgap, input bit rnd_op);
        for (int t = 0; t < n; t++) begin
            logic        wr;
            logic [15:0] a;
            logic [15:0] wd;
            bit          ok;
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge Clock);
                #1;
            end
            wr = rnd_op ? 1'($urandom_range(1, 0)) : 1'b0;
            a  = 16'h0100 + 16'($urandom_range(255, 0));
            wd = 16'($urandom);
            ReadData   = ~wr;
            WriteData  = wr;
            DataAddr   = a;
            DataWrData = wd;
            push_data(wr, a, wd);
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge Clock);
                if (!DataWaitreq) ok = 1'b1;
                @(posedge Clock);
                #1;
            end
            check("data_timeout", 32'(ok), 32'd1);
            ReadData  = 1'b0;
            WriteData = 1'b0;
        end
    endtask

    task automatic drv_fetch(input int n, input int maxgap);
        for (int t = 0; t < n; t++) begin
            logic [15:0] a;
            bit          ok;
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge Clock);
                #1;
            end
            a = 16'h0200 + 16'($urandom_range(255, 0));
            InstrReq  = 1'b1;
            InstrAddr = a;
            fq.push_back(ref_mem[a[9:0]]);
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge Clock);
                if (!InstrWaitreq) ok = 1'b1;
                @(posedge Clock);
                #1;
            end
            check("fetch_timeout", 32'(ok), 32'd1);
            InstrReq = 1'b0;
        end
    endtask

    task automatic rec_issues(output logic [3:0] own, output int cnt);
        own = '0;
        cnt = 0;
        for (int k = 0; k < 300 && cnt < 4; k++) begin
            @(negedge Clock);
            if (MemRdEn || MemWrEn) begin
                own[cnt] = (MemAddr >= 16'h0200);
                cnt++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_maddr"}, 32'(MemAddr), 32'd0);
        check({tag, "_mwdata"}, 32'(MemWrData), 32'd0);
        check({tag, "_rden"}, 32'(MemRdEn), 32'd0);
        check({tag, "_wren"}, 32'(MemWrEn), 32'd0);
        check({tag, "_irdata"}, 32'(InstrRdData), 32'd0);
        check({tag, "_drdata"}, 32'(DataRdData), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] own;
        int         cnt;
        int         d_done;
        int         f_done;
        int         n_iss;
        InstrReq   = 1'b0;
        InstrAddr  = '0;
        ReadData   = 1'b0;
        WriteData  = 1'b0;
        DataAddr   = '0;
        DataWrData = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge Clock);
        #1;
        InstrReq = 1'b1;
        @(negedge Clock);
        check("rst_iwait", 32'(InstrWaitreq), 32'd1);
        check("rst_dwait", 32'(DataWaitreq), 32'd0);
        @(posedge Clock);
        #1;
        InstrReq = 1'b0;
        Reset    = 1'b0;
        @(negedge Clock);
        check_reset_outputs("rst");
        @(posedge Clock);
        #1;

        dtxn(1'b0, 16'h0010, 16'h0, 1'b0, "rd_beef");
        check("beef_hold", 32'(DataRdData), 32'h0000BEEF);
        dtxn(1'b1, 16'h0020, 16'h1234, 1'b0, "wr");
        dtxn(1'b0, 16'h0020, 16'h0, 1'b0, "rd_after_wr");
        check("rd_1234", 32'(DataRdData), 32'h00001234);
        dtxn(1'b0, 16'h0044, 16'h0, 1'b1, "rd_scramble");

        // Collision: data wins, fetch follows after the data access drains.
        d_done = -1;
        f_done = -1;
        n_iss  = 0;
        InstrReq  = 1'b1;
        InstrAddr = 16'h0004;
        fq.push_back(ref_mem[4]);
        ReadData  = 1'b1;
        DataAddr  = 16'h0100;
        push_data(1'b0, 16'h0100, 16'h0);
        for (int k = 0; k < 60; k++) begin
            @(negedge Clock);
            if (MemRdEn) begin
                n_iss++;
                if (n_iss == 1) begin
                    check("col_d_issue", 32'(k), 32'd1);
                    check("col_d_addr", 32'(MemAddr), 32'h0100);
                end else begin
                    check("col_f_issue", 32'(k), 32'(4 + RL));
                    check("col_f_addr", 32'(MemAddr), 32'h0004);
                end
            end
            if (ReadData && !DataWaitreq) d_done = k;
            if (InstrReq && !InstrWaitreq) f_done = k;
            @(posedge Clock);
            #1;
            if (d_done >= 0) ReadData = 1'b0;
            if (f_done >= 0) begin
                InstrReq = 1'b0;
                break;
            end
        end
        check("col_d_done", 32'(d_done), 32'(2 + RL));
        check("col_f_done", 32'(f_done), 32'(5 + 2 * RL));
        check("col_drd_hold", 32'(DataRdData), 32'(ref_mem[16'h0100]));
        ReadData = 1'b0;
        InstrReq = 1'b0;

        // Starvation guard: FMW data grants, then fetch, then data resumes.
        fork
            drv_fetch(1, 0);
            drv_data(4, 0, 1'b0);
            rec_issues(own, cnt);
        join
        check("starve_cnt", 32'(cnt), 32'd4);
        check("starve_order", 32'(own), 32'b0100);

        // Reset lands on the write's ISSUE cycle.
        WriteData  = 1'b1;
        DataAddr   = 16'h0030;
        DataWrData = 16'hDEAD;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        check("rstw_wren", 32'(MemWrEn), 32'd0);
        check("rstw_dwait", 32'(DataWaitreq), 32'd1);
        WriteData = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_outputs("rstw");
        check("rstw_dwait_idle", 32'(DataWaitreq), 32'd0);
        @(posedge Clock);
        #1;
        dtxn(1'b0, 16'h0030, 16'h0, 1'b0, "rd_after_rstw");

        fork
            drv_fetch(30, 6);
            drv_data(40, 3, 1'b1);
        join
        fork
            drv_fetch(25, 0);
            drv_data(30, 0, 1'b1);
        join

        repeat (10) @(posedge Clock);
        check("dq_drained", 32'(dq.size()), 32'd0);
        check("fq_drained", 32'(fq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
